// File: rtl/scara_pkg.sv
// Shared types and defaults for the arctan-core share arbiter.
//   state_e    : arbiter FSM states
//   WORD_W     : width of one packed double-precision operand
//   *_DEFAULT  : default requester count and angle width
package scara_pkg;

  localparam int unsigned WORD_W          = 64;
  localparam int unsigned ANGLE_W_DEFAULT = 13;
  localparam int unsigned NREQ_DEFAULT    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDeliver,
    StFlush
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection.
//   req    : request levels, one bit per requester
//   ptr    : index of the last winner; the search starts just after it and wraps
//   valid  : at least one request is pending
//   winner : index of the selected requester (0 when valid is low)
module rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDX_W'((32'(ptr) + i) % NREQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/atan2_share_arbiter.sv
// Shares one Arctan2 core between NREQ requesters.
//   clk, reset           : clock, asynchronous active-high reset
//   req                  : request levels, held until done or abort
//   arg1_in, arg2_in     : packed y / x operands, WORD_W bits per requester
//   grant                : registered one-hot owner of the core
//   done                 : one-cycle one-hot pulse, angle_out valid for that requester
//   angle_out            : last delivered angle
//   busy                 : high in every state except idle
//   timeout_err          : one-cycle pulse when the core never signals ready
//   core_arg1, core_arg2 : registered operands to the core
//   core_enable          : core enable, high only while running
//   core_reset           : core synchronous reset, the complement of core_enable
//   core_angle           : core result
//   core_ready           : core data-ready level
module atan2_share_arbiter
  import scara_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEFAULT,
  parameter int unsigned ANGLE_W = ANGLE_W_DEFAULT,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [WORD_W*NREQ-1:0]    arg1_in,
  input  logic [WORD_W*NREQ-1:0]    arg2_in,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic signed [ANGLE_W-1:0] angle_out,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [WORD_W-1:0]         core_arg1,
  output logic [WORD_W-1:0]         core_arg2,
  output logic                      core_enable,
  output logic                      core_reset,
  input  logic signed [ANGLE_W-1:0] core_angle,
  input  logic                      core_ready
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CntMax    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntWarn   = CNT_W'(TIMEOUT - 1);

  state_e                     state_q, state_d;
  logic [NREQ-1:0]            grant_q, grant_d;
  logic [NREQ-1:0]            done_q, done_d;
  logic [IDX_W-1:0]           owner_q, owner_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [ANGLE_W-1:0]  angle_q, angle_d;
  logic [WORD_W-1:0]          arg1_q, arg1_d, arg2_q, arg2_d;
  logic                       tmo_q, tmo_d;
  logic                       pick_valid;
  logic [IDX_W-1:0]           pick_idx;
  logic                       owner_req;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign owner_req = req[owner_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    angle_d = angle_q;
    arg1_d  = arg1_q;
    arg2_d  = arg2_q;
    done_d  = '0;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d = '0;
        if (!owner_req) begin
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = StFlush;
        end else begin
          arg1_d  = WORD_W'(arg1_in >> (WORD_W * owner_q));
          arg2_d  = WORD_W'(arg2_in >> (WORD_W * owner_q));
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The error pulse was issued one cycle ahead so it stays registered;
        // reaching the limit simply ends the transaction.
        if (cnt_q == CntMax) begin
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = StFlush;
        end else if (!owner_req) begin
          // An owner drop beats a coincident core_ready.
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = StFlush;
        end else if (core_ready) begin
          angle_d = core_angle;
          done_d  = grant_q;
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = StDeliver;
        end else if (cnt_q == CntWarn) begin
          tmo_d = 1'b1;
        end
      end
      StDeliver: state_d = StFlush;
      StFlush:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
      angle_q <= '0;
      arg1_q  <= '0;
      arg2_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      angle_q <= angle_d;
      arg1_q  <= arg1_d;
      arg2_q  <= arg2_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign angle_out   = angle_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = tmo_q;
  assign core_arg1   = arg1_q;
  assign core_arg2   = arg2_q;
  assign core_enable = (state_q == StRun);
  assign core_reset  = (state_q != StRun);

endmodule
